// File: rtl/mem_loader_if.sv
// Host byte stream and memory write port of the program loader.
// master: the loader side; slave: the host/memory side.
interface mem_loader_if #(
    parameter int Reg_size  = 32,
    parameter int Addr_bits = 8
);
    logic [7:0]           rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 mem_we;
    logic [Addr_bits-1:0] mem_addr;
    logic [Reg_size-1:0]  mem_wdata;
    logic                 cpu_en;
    logic                 busy;
    logic                 done;
    logic                 err;

    modport master (
        input  rx_data, rx_valid,
        output rx_ready, mem_we, mem_addr, mem_wdata, cpu_en, busy, done, err
    );

    modport slave (
        output rx_data, rx_valid,
        input  rx_ready, mem_we, mem_addr, mem_wdata, cpu_en, busy, done, err
    );
endinterface

// File: rtl/mem_loader.sv
// Byte-stream program loader: decodes host commands, assembles little-endian
// words and writes them to data memory while holding the processor.
//
// state      | meaning
// -----------+----------------------------------------------------------
// S_IDLE     | waiting for a command byte (LOAD / RUN / HALT)
// S_GET_ADDR | next byte is the start word address
// S_GET_CNT  | next byte is the number of words to load
// S_GET_BYTE | collecting the bytes of the current word
// S_WRITE    | one-cycle memory write of the assembled word
module mem_loader #(
    parameter int Reg_size  = 32,
    parameter int Addr_bits = 8
) (
    input  logic clk,
    input  logic rst,
    mem_loader_if.master io_bus
);
    localparam int NB    = Reg_size / 8;
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NB - 1);

    localparam logic [7:0] CMD_LOAD = 8'hA5;
    localparam logic [7:0] CMD_RUN  = 8'h5A;
    localparam logic [7:0] CMD_HALT = 8'h0F;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_ADDR,
        S_GET_CNT,
        S_GET_BYTE,
        S_WRITE
    } state_t;

    state_t               r_state;
    logic [Addr_bits-1:0] r_addr;
    logic [7:0]           r_cnt;
    logic [IDX_W-1:0]     r_idx;
    logic [Reg_size-1:0]  r_word;
    logic                 r_rx_ready;
    logic                 r_mem_we;
    logic [Addr_bits-1:0] r_mem_addr;
    logic [Reg_size-1:0]  r_mem_wdata;
    logic                 r_cpu_en;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_err;

    logic                  w_xfer;
    logic [Reg_size+7:0]   w_shift;
    logic [Reg_size-1:0]   w_word_next;

    // New bytes enter at the top and shift down, so after NB bytes the first
    // one received sits in bits [7:0] and no stale data survives.
    assign w_xfer      = io_bus.rx_valid && r_rx_ready;
    assign w_shift     = {io_bus.rx_data, r_word};
    assign w_word_next = w_shift[Reg_size+7:8];

    // Loader FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_word      <= '0;
            r_rx_ready  <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cpu_en    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_mem_we <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_xfer) begin
                        case (io_bus.rx_data)
                            CMD_LOAD: begin
                                r_cpu_en <= 1'b0;
                                r_busy   <= 1'b1;
                                r_state  <= S_GET_ADDR;
                            end
                            CMD_RUN:  r_cpu_en <= 1'b1;
                            CMD_HALT: r_cpu_en <= 1'b0;
                            default:  r_err    <= 1'b1;
                        endcase
                    end
                end
                S_GET_ADDR: begin
                    if (w_xfer) begin
                        r_addr  <= Addr_bits'(io_bus.rx_data);
                        r_state <= S_GET_CNT;
                    end
                end
                S_GET_CNT: begin
                    if (w_xfer) begin
                        r_cnt <= io_bus.rx_data;
                        r_idx <= '0;
                        if (io_bus.rx_data == 8'd0) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_GET_BYTE;
                        end
                    end
                end
                S_GET_BYTE: begin
                    if (w_xfer) begin
                        r_word <= w_word_next;
                        if (r_idx == IDX_LAST) begin
                            // Present the write in the cycle right after the last byte.
                            r_idx       <= '0;
                            r_rx_ready  <= 1'b0;
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= r_addr;
                            r_mem_wdata <= w_word_next;
                            r_state     <= S_WRITE;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    r_addr     <= r_addr + 1'b1;
                    r_cnt      <= r_cnt - 8'd1;
                    r_rx_ready <= 1'b1;
                    if (r_cnt == 8'd1) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_GET_BYTE;
                    end
                end
                default: begin
                    r_busy     <= 1'b0;
                    r_rx_ready <= 1'b1;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign io_bus.rx_ready  = r_rx_ready;
    assign io_bus.mem_we    = r_mem_we;
    assign io_bus.mem_addr  = r_mem_addr;
    assign io_bus.mem_wdata = r_mem_wdata;
    assign io_bus.cpu_en    = r_cpu_en;
    assign io_bus.busy      = r_busy;
    assign io_bus.done      = r_done;
    assign io_bus.err       = r_err;
endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: command decode, word loads, address wrap,
// stalls, error pulse and mid-load reset.
module tb_mem_loader;
    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_loader_if #(.Reg_size(32), .Addr_bits(8)) bus();

    mem_loader #(.Reg_size(32), .Addr_bits(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]  got_addr[$];
    logic [31:0] got_data[$];
    logic [7:0]  exp_addr[$];
    logic [31:0] exp_data[$];

    int n_done     = 0;
    int n_err      = 0;
    int n_de       = 0;
    int n_rdy_viol = 0;
    int n_cpu_viol = 0;

    // Sample outputs mid-cycle, away from the rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.mem_we) begin
                got_addr.push_back(bus.mem_addr);
                got_data.push_back(bus.mem_wdata);
            end
            if (bus.done) n_done++;
            if (bus.err) n_err++;
            if (bus.done && bus.err) n_de++;
            if (bus.rx_ready == bus.mem_we) n_rdy_viol++;
            if (bus.busy && bus.cpu_en) n_cpu_viol++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called and returns at a falling edge; holds valid until the byte is taken.
    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        for (int i = 0; i < 20 && !ok; i++) begin
            ok = bus.rx_ready;
            @(negedge clk);
        end
        bus.rx_valid = 1'b0;
        if (!ok) chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_seq(input bq_t q, input bit gaps);
        foreach (q[i]) begin
            if (gaps) idle($urandom_range(0, 2));
            send_byte(q[i]);
        end
    endtask

    task automatic wait_done(input string tag);
        int start;
        start = n_done;
        for (int i = 0; i < 40 && n_done == start; i++) @(negedge clk);
        idle(1);
        chk({tag, "_done"}, 64'(n_done - start), 64'd1);
    endtask

    task automatic check_writes(input string tag);
        chk({tag, "_nwr"}, 64'(got_addr.size()), 64'(exp_addr.size()));
        foreach (exp_addr[i]) begin
            if (i < got_addr.size()) begin
                chk($sformatf("%s_addr%0d", tag, i), 64'(got_addr[i]), 64'(exp_addr[i]));
                chk($sformatf("%s_data%0d", tag, i), 64'(got_data[i]), 64'(exp_data[i]));
            end
        end
        got_addr.delete(); got_data.delete();
        exp_addr.delete(); exp_data.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_flags"},
            64'({bus.cpu_en, bus.mem_we, bus.done, bus.err, bus.busy, bus.rx_ready}),
            64'b000001);
        chk({tag, "_addr"}, 64'(bus.mem_addr), 64'h0);
        chk({tag, "_wdata"}, 64'(bus.mem_wdata), 64'h0);
    endtask

    initial begin
        bq_t q;
        int e0;
        logic [31:0] w;
        logic [7:0] b;

        rst = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        idle(3);
        rst = 1'b0;
        check_reset_outputs("reset");

        // Two-word load at 0x10
        q = '{8'hA5, 8'h10, 8'h02, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        exp_addr.push_back(8'h10); exp_data.push_back(32'h12345678);
        exp_addr.push_back(8'h11); exp_data.push_back(32'hDEADBEEF);
        send_seq(q, 1'b0);
        wait_done("two_word");
        check_writes("two_word");
        chk("two_word_busy", 64'(bus.busy), 64'd0);

        // Address wrap from 0xFF to 0x00
        q = '{8'hA5, 8'hFF, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        exp_addr.push_back(8'hFF); exp_data.push_back(32'h04030201);
        exp_addr.push_back(8'h00); exp_data.push_back(32'h08070605);
        send_seq(q, 1'b0);
        wait_done("wrap");
        check_writes("wrap");

        // Zero-word load, then RUN and HALT
        q = '{8'hA5, 8'h20, 8'h00};
        send_seq(q, 1'b0);
        wait_done("zero_cnt");
        check_writes("zero_cnt");
        chk("zero_cnt_busy", 64'(bus.busy), 64'd0);
        send_byte(8'h5A);
        chk("run_cpu_en", 64'(bus.cpu_en), 64'd1);
        send_byte(8'h0F);
        chk("halt_cpu_en", 64'(bus.cpu_en), 64'd0);

        // Unknown command while running, then a normal load
        send_byte(8'h5A);
        e0 = n_err;
        send_byte(8'h33);
        idle(2);
        chk("bad_cmd_err", 64'(n_err - e0), 64'd1);
        chk("bad_cmd_cpu_en", 64'(bus.cpu_en), 64'd1);
        chk("bad_cmd_busy", 64'(bus.busy), 64'd0);
        q = '{8'hA5, 8'h40, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
        exp_addr.push_back(8'h40); exp_data.push_back(32'h44332211);
        send_seq(q, 1'b0);
        wait_done("after_err");
        check_writes("after_err");
        chk("after_err_cpu_en", 64'(bus.cpu_en), 64'd0);

        // Four-word load with random idle gaps on rx_valid
        q = '{8'hA5, 8'h80, 8'h04};
        for (int k = 0; k < 4; k++) begin
            w = '0;
            for (int j = 0; j < 4; j++) begin
                b = 8'(8'h30 + k * 4 + j);
                q.push_back(b);
                w[j*8 +: 8] = b;
            end
            exp_addr.push_back(8'(8'h80 + k));
            exp_data.push_back(w);
        end
        send_seq(q, 1'b1);
        wait_done("gappy");
        check_writes("gappy");

        // Reset after two data bytes abandons the load
        q = '{8'hA5, 8'h60, 8'h02, 8'hAA, 8'hBB};
        send_seq(q, 1'b0);
        idle(1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check_reset_outputs("mid_rst");
        idle(3);
        check_writes("mid_rst");
        q = '{8'hA5, 8'h61, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        exp_addr.push_back(8'h61); exp_data.push_back(32'hDDCCBBAA);
        send_seq(q, 1'b0);
        wait_done("post_rst");
        check_writes("post_rst");

        chk("ready_only_low_in_write", 64'(n_rdy_viol), 64'd0);
        chk("cpu_en_low_while_busy", 64'(n_cpu_viol), 64'd0);
        chk("done_err_exclusive", 64'(n_de), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 Parameter Reg_size, default 32: memory data word width (multiple of 8).
REQ-002 Parameter Addr_bits, default 8: memory word-address width.
REQ-003 clk  input  1  system clock; one clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 rx_data  input  8  host command/data byte.
REQ-006 rx_valid  input  1  rx_data valid this cycle.
REQ-007 rx_ready  output  1  loader accepts byte this cycle; transfer when rx_valid&&rx_ready.
REQ-008 mem_we  output  1  one-cycle write strobe to data memory port.
REQ-009 mem_addr  output  Addr_bits  memory word address.
REQ-010 mem_wdata  output  Reg_size  memory write data.
REQ-011 cpu_en  output  1  processor run enable; 0 holds PC and gives memory port to loader.
REQ-012 busy  output  1  high whenever state != IDLE.
REQ-013 done  output  1  one-cycle pulse after final word of a load is written.
REQ-014 err  output  1  one-cycle pulse on unknown command byte.

Function
REQ-015 States: IDLE, GET_ADDR, GET_CNT, GET_BYTE, WRITE.
REQ-016 rx_ready SHALL be 1 in IDLE, GET_ADDR, GET_CNT, GET_BYTE; 0 in WRITE; never depends combinationally on rx_valid.
REQ-017 IDLE, accepted 0xA5 (LOAD): cpu_en<=0, -> GET_ADDR.
REQ-018 IDLE, accepted 0x5A (RUN): cpu_en<=1, stay IDLE.
REQ-019 IDLE, accepted 0x0F (HALT): cpu_en<=0, stay IDLE.
REQ-020 IDLE, any other accepted byte: err=1 next cycle for exactly one cycle, no other state change.
REQ-021 GET_ADDR: accepted byte loads address register (zero-extended/truncated to Addr_bits), -> GET_CNT.
REQ-022 GET_CNT: accepted byte loads word counter; value 0 -> IDLE with done pulse and no write; else -> GET_BYTE, byte index=0.
REQ-023 GET_BYTE: bytes assemble little-endian (first byte -> bits [7:0]); after Reg_size/8-th byte -> WRITE.
REQ-024 WRITE: exactly one cycle; mem_we=1, mem_addr=address register, mem_wdata=assembled word; then address+1 (wraps mod 2^Addr_bits), counter-1.
REQ-025 After WRITE: counter nonzero -> GET_BYTE; counter zero -> IDLE with done=1 for one cycle.
REQ-026 mem_we SHALL be 0 in every state other than WRITE; mem_addr/mem_wdata hold last values between writes.
REQ-027 Cycles with rx_valid=0 SHALL stall the FSM with no state or output change (no timeout).
REQ-028 cpu_en SHALL remain 0 for the whole load; loader never sets cpu_en=1 except on RUN.
REQ-029 Load latency: WRITE occurs the cycle after the last byte of a word is accepted; at most one byte accepted per cycle.
REQ-030 done and err never asserted simultaneously.

Reset
REQ-031 rst=1 at a clock edge SHALL force: state IDLE, cpu_en=0, mem_we=0, mem_addr=0, mem_wdata=0, done=0, err=0, counters/byte index 0; busy=0 and rx_ready=1 the following cycle.
REQ-032 rst mid-load SHALL abandon the load with no further mem_we; partially assembled word discarded.
REQ-033 rst has priority over any simultaneous byte transfer.

Verification
REQ-034 Bytes A5,10,02,78,56,34,12,EF,BE,AD,DE -> mem_we at addr 0x10 data 0x12345678, addr 0x11 data 0xDEADBEEF, then done pulse, busy=0.
REQ-035 Bytes A5,FF,02 + 8 data bytes -> writes at addr 0xFF then 0x00 (wrap).
REQ-036 Bytes A5,20,00 -> no mem_we, done pulse, back to IDLE; then 5A -> cpu_en=1; then 0F -> cpu_en=0.
REQ-037 Byte 33 in IDLE -> err one cycle, cpu_en and state unchanged; next A5 accepted normally.
REQ-038 rx_valid toggled randomly during a 4-word load -> same writes as contiguous stream; rx_ready=0 only in WRITE cycles.
REQ-039 rst=1 after 2 data bytes of a load -> no mem_we, all outputs at reset values, subsequent complete load writes correctly.
